// File: rtl/div_seq_pkg.sv
// Shared definitions for the multi-cycle divider: bus widths, FSM state codes,
// handshake levels and the operand magnitude helper.
package div_seq_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam int CNT_W          = 5;

  localparam logic [CNT_W-1:0] DIV_LAST_CNT = 5'd31;

  localparam logic DIV_START           = 1'b1;
  localparam logic DIV_STOP            = 1'b0;
  localparam logic DIV_RESULT_READY    = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BYZERO  = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Magnitude of a two's-complement word, or the raw word for unsigned ops.
  function automatic logic [REG_BUS-1:0] abs_if(input logic [REG_BUS-1:0] v,
                                                input logic              en);
    return (en && v[REG_BUS-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_seq.sv
// 32-iteration restoring divider with divide-by-zero short cut, annulment and
// pipeline stall request; result is {remainder, quotient}.
module div_seq
  import div_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o,
  output logic                      stallreq_o
);

  div_state_e                state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [REG_BUS-1:0]        rem_reg, rem_next;
  logic [REG_BUS-1:0]        quot_reg, quot_next;
  logic [REG_BUS-1:0]        divisor_reg, divisor_next;
  logic                      neg_quot_reg, neg_quot_next;
  logic                      neg_rem_reg, neg_rem_next;
  logic [DOUBLE_REG_BUS-1:0] result_reg, result_next;
  logic                      ready_reg, ready_next;

  logic [REG_BUS:0]   rem_shift;
  logic               trial_borrow;
  logic [REG_BUS-1:0] trial_diff;
  logic               trial_ok;
  logic [REG_BUS-1:0] step_rem;
  logic [REG_BUS-1:0] step_quot;
  logic [REG_BUS-1:0] fix_rem;
  logic [REG_BUS-1:0] fix_quot;
  logic               go;

  // One restoring step. A set top bit of the shifted remainder already
  // exceeds any 32-bit divisor, so the low 33-bit subtract is sufficient.
  assign rem_shift = {rem_reg, quot_reg[REG_BUS-1]};
  assign {trial_borrow, trial_diff} = {1'b0, rem_shift[REG_BUS-1:0]} - {1'b0, divisor_reg};
  assign trial_ok  = rem_shift[REG_BUS] | ~trial_borrow;
  assign step_rem  = trial_ok ? trial_diff : rem_shift[REG_BUS-1:0];
  assign step_quot = {quot_reg[REG_BUS-2:0], trial_ok};
  assign fix_quot  = neg_quot_reg ? (~step_quot + 1'b1) : step_quot;
  assign fix_rem   = neg_rem_reg  ? (~step_rem + 1'b1)  : step_rem;

  assign go = (start_i == DIV_START) && !annul_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= DIV_FREE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      divisor_reg  <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_reg   <= '0;
      ready_reg    <= DIV_RESULT_NOT_READY;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rem_reg      <= rem_next;
      quot_reg     <= quot_next;
      divisor_reg  <= divisor_next;
      neg_quot_reg <= neg_quot_next;
      neg_rem_reg  <= neg_rem_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rem_next      = rem_reg;
    quot_next     = quot_reg;
    divisor_next  = divisor_reg;
    neg_quot_next = neg_quot_reg;
    neg_rem_next  = neg_rem_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
    stallreq_o    = 1'b0;

    case (state_reg)
      DIV_FREE: begin
        stallreq_o = go;
        if (go) begin
          if (opdata2_i == '0) begin
            state_next = DIV_BYZERO;
          end else begin
            state_next    = DIV_ON;
            cnt_next      = '0;
            rem_next      = '0;
            quot_next     = abs_if(opdata1_i, signed_div_i);
            divisor_next  = abs_if(opdata2_i, signed_div_i);
            neg_quot_next = signed_div_i & (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
            neg_rem_next  = signed_div_i & opdata1_i[REG_BUS-1];
          end
        end
      end
      DIV_BYZERO: begin
        stallreq_o = !annul_i;
        if (annul_i) begin
          state_next = DIV_FREE;
        end else begin
          state_next  = DIV_END;
          result_next = '0;
          ready_next  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        stallreq_o = !annul_i;
        if (!go) begin
          state_next  = DIV_FREE;
          result_next = '0;
        end else begin
          rem_next  = step_rem;
          quot_next = step_quot;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == DIV_LAST_CNT) begin
            state_next  = DIV_END;
            result_next = {fix_rem, fix_quot};
            ready_next  = DIV_RESULT_READY;
          end
        end
      end
      DIV_END: begin
        // Result is held until EX drops start, so it is never missed.
        if (start_i == DIV_STOP || annul_i) begin
          state_next  = DIV_FREE;
          ready_next  = DIV_RESULT_NOT_READY;
          result_next = '0;
        end
      end
      default: state_next = DIV_FREE;
    endcase
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: expected results queued at start, compared
// when ready_o rises; latency, stall length, annul and async reset covered.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives one division from the current (post-edge) time and checks it.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_edges, input int exp_stall, input int hold);
    logic [63:0] exp_val;
    logic [63:0] held;
    int edges;
    int stall_cnt;
    bit done;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp_res);
    #1;
    edges = 0; stall_cnt = 0; done = 0;
    while (!done && edges < 100) begin
      if (stallreq_o) stall_cnt++;
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      if (ready_o) done = 1;
    end
    exp_val = exp_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: ready_o=%0b after %0d edges, required 1", name, ready_o, edges);
    end
    checks++;
    if (edges !== exp_edges) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, edges, exp_edges);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", name, stall_cnt, exp_stall);
    end
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_in_end: got %0b, required 0", name, stallreq_o);
    end
    checks++;
    if (result_o !== exp_val) begin
      errors++;
      $display("FAIL %s result: got %h, required %h", name, result_o, exp_val);
    end
    held = result_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ready_o !== 1'b1 || result_o !== held) begin
        errors++;
        $display("FAIL %s hold%0d: ready=%0b result=%h, required ready=1 result=%h",
                 name, i, ready_o, result_o, held);
      end
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL %s release: ready=%0b result=%h, required 0/0", name, ready_o, result_o);
    end
    $display("div %s: a=%h b=%h signed=%0b result=%h edges=%0d stall=%0d",
             name, a, b, sgn, exp_val, edges, stall_cnt);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b result=%h stall=%0b, required 0/0/0",
               ready_o, result_o, stallreq_o);
    end
    start_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_follows_start: got %0b, required 1", stallreq_o);
    end
    start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  task automatic test_unsigned();
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 33, 0);
  endtask

  task automatic test_signed();
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 33, 0);
    run_div("div_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 33, 0);
  endtask

  task automatic test_byzero();
    run_div("div_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 2, 5);
  endtask

  task automatic test_annul();
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      errors++;
      $display("FAIL annul_pre_stall: got %0b, required 1", stallreq_o);
    end
    annul_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL annul_stall_drop: got %0b, required 0", stallreq_o);
    end
    @(posedge clk); #1;
    annul_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL annul_abort: ready=%0b result=%h, required 0/0", ready_o, result_o);
    end
    $display("annul: aborted at cnt=10");
    // Start is still high: a fresh run must take the full 33 edges.
    run_div("divu_ffffffff_10", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, 33, 0);
  endtask

  task automatic test_async_reset();
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    start_i = 1'b0;
    rst     = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%0b result=%h stall=%0b, required 0/0/0",
               ready_o, result_o, stallreq_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    $display("async_reset: done");
    run_div("divu_100_7_again", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 33, 0);
  endtask

  task automatic test_overflow();
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 33, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? ($urandom | 32'h1) : ($urandom_range(1, 65535));
      s = i[0];
      run_div($sformatf("b2b_%0d", i), s, a, b, div_model(s, a, b), 33, 33, i % 2);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_async_reset();
    test_overflow();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
